// File: rtl/latch_evt_pkg.sv
// Shared types and helpers for the latch edge capture block.
package latch_evt_pkg;

  parameter int TS_W = 16;
  localparam int DROP_W = 8;

  typedef struct packed {
    logic            rise;
    logic [TS_W-1:0] ts;
  } evt_t;

  // Drop counter increments but sticks at all-ones instead of wrapping.
  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == {DROP_W{1'b1}}) ? v : v + DROP_W'(1);
  endfunction

endpackage

// File: rtl/evt_sync_fifo.sv
// Small synchronous FIFO for edge events; head entry is visible combinationally.
module evt_sync_fifo
  import latch_evt_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = $bits(evt_t)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  // A write into a full FIFO is legal only when the head leaves in the same cycle.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
    end
  end

endmodule

// File: rtl/latch_edge_capture.sv
// Synchronises a d_latch q level, timestamps its edges and queues them for a consumer.
// Optional glitch filter enabled by defining LATCH_GLITCH_FILTER_EN.
module latch_edge_capture
  import latch_evt_pkg::*;
#(
  parameter int TS_W       = latch_evt_pkg::TS_W,
  parameter int DEPTH      = 4,
  parameter int FILTER_LEN = 3
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   q_in,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic                   evt_rise,
  output logic [TS_W-1:0]        evt_ts,
  output logic [$clog2(DEPTH):0] evt_count,
  input  logic                   ovf_clr,
  output logic                   ovf,
  output logic [DROP_W-1:0]      drop_cnt
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || FILTER_LEN < 1) begin : g_param_check
    $error("latch_edge_capture: DEPTH must be a power of 2 >= 2 and FILTER_LEN >= 1");
  end

  logic            s1, s2, lvl, lvl_d;
  logic [TS_W-1:0] ts_cnt;
  logic            edge_det, pop, fifo_full, fifo_empty, drop;
  logic [TS_W:0]   fifo_dout;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      lvl_d  <= 1'b0;
      ts_cnt <= '0;
    end else begin
      s1     <= q_in;
      s2     <= s1;
      lvl_d  <= lvl;
      ts_cnt <= ts_cnt + TS_W'(1);
    end
  end

`ifdef LATCH_GLITCH_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN + 1);
  logic [FW-1:0] filt_cnt;

  // lvl follows s2 only once s2 has disagreed with it for FILTER_LEN straight cycles.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lvl      <= 1'b0;
      filt_cnt <= '0;
    end else if (s2 == lvl) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
      lvl      <= s2;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + FW'(1);
    end
  end
`else
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) lvl <= 1'b0;
    else       lvl <= s2;
  end
`endif

  assign edge_det  = lvl ^ lvl_d;
  assign evt_valid = !fifo_empty;
  assign pop       = evt_valid && evt_ready;
  assign drop      = edge_det && fifo_full && !pop;
  assign evt_rise  = fifo_dout[TS_W];
  assign evt_ts    = fifo_dout[TS_W-1:0];

  evt_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (TS_W + 1)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (edge_det),
    .din   ({lvl, ts_cnt}),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (evt_count)
  );

  // A drop in the same cycle as a clear restarts the count at one.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      ovf      <= 1'b1;
      drop_cnt <= ovf_clr ? DROP_W'(1) : sat_inc(drop_cnt);
    end else if (ovf_clr) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end
  end

endmodule
